// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_INC   = 3'b100,
    OP_PASSB = 3'b101,
    OP_MUL   = 3'b110,
    OP_CLR   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Shift-add multiplier: one partial-product iteration per step, WIDTH steps per product.
module shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               step,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // product already includes the current iteration, so the controller can
  // capture the final value on the same edge as the last step.
  always_comb begin
    product = acc + (mplier[0] ? mcand : '0);
  end

  assign last = (count == CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      count  <= CW'(WIDTH);
    end else if (step && (count != '0)) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle 8-bit ALU for the accumulator path: one op per start, registered
// result and flags, one-cycle ac_set/done strobe at completion.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             ac_set,
  output logic             done,
  output logic             busy,
  output logic             z_flag,
  output logic             c_flag
);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [WIDTH:0]     alu_wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [2*WIDTH-1:0] product;
  logic               mul_last;
  logic               mul_load;
  logic               mul_step;

  // Single-cycle datapath; the extra MSB carries carry-out or borrow.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    alu_wide = '0;
    case (op_q)
      OP_ADD:   alu_wide = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:   alu_wide = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:   alu_wide = {1'b0, a_q & b_q};
      OP_OR:    alu_wide = {1'b0, a_q | b_q};
      OP_INC:   alu_wide = {1'b0, a_q} + (WIDTH+1)'(1);
      OP_PASSB: alu_wide = {1'b0, b_q};
      default:  alu_wide = '0;  // CLR, and MUL when the multiplier is disabled
    endcase
  end

  assign alu_res = alu_wide[WIDTH-1:0];
  assign alu_c   = alu_wide[WIDTH];

  assign mul_load = (state == S_IDLE) && start;
  assign mul_step = (state == S_MUL);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (a_in),
    .b       (b_in),
    .step    (mul_step),
    .product (product),
    .last    (mul_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      done   <= 1'b0;
      ac_set <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done   <= 1'b0;
      ac_set <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op_t'(op);
            a_q   <= a_in;
            b_q   <= b_in;
            busy  <= 1'b1;
            state <= (MUL_EN && (op_t'(op) == OP_MUL)) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          result <= alu_res;
          z_flag <= (alu_res == '0);
          c_flag <= alu_c;
          done   <= 1'b1;
          ac_set <= 1'b1;
          state  <= S_DONE;
        end
        S_MUL: begin
          if (mul_last) begin
            result <= product[WIDTH-1:0];
            z_flag <= (product[WIDTH-1:0] == '0);
            c_flag <= |product[2*WIDTH-1:WIDTH];
            done   <= 1'b1;
            ac_set <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: transaction-level reference model compared
// every cycle, plus hand-computed expectations for the directed vectors.
module tb_seq_alu;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] result;
  logic             ac_set;
  logic             done;
  logic             busy;
  logic             z_flag;
  logic             c_flag;

  int n_checks = 0;
  int n_fails  = 0;
  bit check_en = 1'b0;

  seq_alu #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .result (result),
    .ac_set (ac_set),
    .done   (done),
    .busy   (busy),
    .z_flag (z_flag),
    .c_flag (c_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void ref_eval(input int o, input int a, input int b,
                                   output int res, output int c);
    int full;
    case (o)
      0: full = a + b;
      1: full = a - b;
      2: full = a & b;
      3: full = a | b;
      4: full = a + 1;
      5: full = b;
      6: full = a * b;
      default: full = 0;
    endcase
    res = full & 255;
    case (o)
      0, 4:    c = (full > 255) ? 1 : 0;
      1:       c = (a < b) ? 1 : 0;
      6:       c = (full > 255) ? 1 : 0;
      default: c = 0;
    endcase
  endfunction

  // Transaction model: an accepted op completes after its latency in edges,
  // announces done for one cycle, then frees the unit one edge later.
  int m_busy = 0, m_done = 0, m_res = 0, m_z = 0, m_c = 0;
  int m_cnt = 0, m_lat = 0, m_op = 0, m_a = 0, m_b = 0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_busy = 0; m_done = 0; m_res = 0; m_z = 0; m_c = 0;
    end else if (m_busy == 0) begin
      m_done = 0;
      if (start === 1'b1) begin
        m_busy = 1; m_cnt = 0;
        m_op = int'(op); m_a = int'(a_in); m_b = int'(b_in);
        m_lat = (m_op == 6) ? WIDTH : 1;
      end
    end else begin
      m_done = 0;
      m_cnt++;
      if (m_cnt == m_lat) begin
        ref_eval(m_op, m_a, m_b, m_res, m_c);
        m_z = (m_res == 0) ? 1 : 0;
        m_done = 1;
      end else if (m_cnt == m_lat + 1) begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_result", int'(result), m_res);
      check("cyc_z",      int'(z_flag), m_z);
      check("cyc_c",      int'(c_flag), m_c);
      check("cyc_done",   int'(done),   m_done);
      check("cyc_ac_set", int'(ac_set), m_done);
      check("cyc_busy",   int'(busy),   m_busy);
    end
  end

  // Runs one op; returns done latency in edges after the accepting edge and
  // the number of cycles busy was high. Operands are scrambled after launch.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cyc);
    int n;
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = ~a; b_in = ~b; op = 3'b111;
    lat = -1; busy_cyc = 0; n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      busy_cyc++;
      if (done === 1'b1 && lat < 0) lat = busy_cyc - 1;
      @(negedge clk);
    end
    if (n >= 40) check("timeout_busy", 1, 0);
  endtask

  task automatic expect_op(input string name, input logic [2:0] o,
                           input logic [7:0] a, input logic [7:0] b,
                           input int e_res, input int e_z, input int e_c,
                           input int e_lat, input int e_busy);
    int lat, bc;
    run_op(o, a, b, lat, bc);
    check({name, "_result"}, int'(result), e_res);
    check({name, "_z"},      int'(z_flag), e_z);
    check({name, "_c"},      int'(c_flag), e_c);
    check({name, "_lat"},    lat,          e_lat);
    check({name, "_busy"},   bc,           e_busy);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    @(posedge clk);
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_busy",   int'(busy),   0);
    check("reset_done",   int'(done),   0);
    rst = 1'b0;

    //          name      op      a      b      res   z  c  lat busy
    expect_op("add_7f",  3'b000, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 2);
    expect_op("add_ff",  3'b000, 8'hFF, 8'h01, 8'h00, 1, 1, 1, 2);
    expect_op("sub_neg", 3'b001, 8'h05, 8'h07, 8'hFE, 0, 1, 1, 2);
    expect_op("mul_c_b", 3'b110, 8'h0C, 8'h0B, 8'h84, 0, 0, 8, 9);
    expect_op("mul_ovf", 3'b110, 8'h10, 8'h10, 8'h00, 1, 1, 8, 9);
    expect_op("mul_ff",  3'b110, 8'hFF, 8'hFF, 8'h01, 0, 1, 8, 9);
    expect_op("and",     3'b010, 8'hF0, 8'h3C, 8'h30, 0, 0, 1, 2);
    expect_op("or",      3'b011, 8'hA0, 8'h05, 8'hA5, 0, 0, 1, 2);
    expect_op("inc_ff",  3'b100, 8'hFF, 8'h12, 8'h00, 1, 1, 1, 2);
    expect_op("passb",   3'b101, 8'h11, 8'h5A, 8'h5A, 0, 0, 1, 2);
    expect_op("clr",     3'b111, 8'hFF, 8'hFF, 8'h00, 1, 0, 1, 2);
    expect_op("sub_eq",  3'b001, 8'h42, 8'h42, 8'h00, 1, 0, 1, 2);

    // Start pulsed while a MUL is in flight must be ignored.
    @(negedge clk);
    op = 3'b110; a_in = 8'h03; b_in = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = 3'b111; a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) @(negedge clk);
    check("busy_ign_result", int'(result), 8'h0F);
    check("busy_ign_busy",   int'(busy),   0);

    // Reset at cycle 4 of a MUL aborts without a completion strobe.
    @(negedge clk);
    op = 3'b110; a_in = 8'h12; b_in = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",   int'(busy),   0);
    check("abort_result", int'(result), 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || ac_set === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    // Reset and start together: reset wins and the start is dropped.
    expect_op("pre_rs", 3'b101, 8'h00, 8'h77, 8'h77, 0, 0, 1, 2);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 3'b000; a_in = 8'h01; b_in = 8'h01;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy",   int'(busy),   0);
    check("rst_start_result", int'(result), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
